// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   MDU_DATA_SIZE    default operand and HI/LO width
//   MDU_MULT..DIVU   2-bit op codes (also used by the control decoder)
//   mdu_state_e      control FSM states
//   op_is_div/op_is_signed   op-code decode helpers
package mdu_pkg;

    localparam int MDU_DATA_SIZE = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_PREP = 2'b01,
        MDU_CALC = 2'b10,
        MDU_FIX  = 2'b11
    } mdu_state_e;

    // Bit 1 of the op code separates divide from multiply.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 set means the unsigned flavour.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the MDU.
//   i_start, i_op, i_data_a, i_data_b   operation request and operands
//   i_mthi, i_mtlo                      move-to-HI/LO requests (data on i_data_a)
//   o_busy, o_done, o_hi, o_lo          status and architectural HI/LO
// master: EX-stage side; slave: the MDU itself.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int DATA_SIZE = MDU_DATA_SIZE
);
    logic                 i_start;
    logic [1:0]           i_op;
    logic [DATA_SIZE-1:0] i_data_a;
    logic [DATA_SIZE-1:0] i_data_b;
    logic                 i_mthi;
    logic                 i_mtlo;
    logic                 o_busy;
    logic                 o_done;
    logic [DATA_SIZE-1:0] o_hi;
    logic [DATA_SIZE-1:0] o_lo;

    modport master (
        output i_start, i_op, i_data_a, i_data_b, i_mthi, i_mtlo,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_data_a, i_data_b, i_mthi, i_mtlo,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division iteration.
//   i_rem      partial remainder (DATA_SIZE+1 bits)
//   i_bit      next dividend bit shifted in at the bottom
//   i_divisor  divisor magnitude
//   o_rem      next partial remainder
//   o_q        quotient bit produced by this iteration
module mdu_div_step #(
    parameter int DATA_SIZE = 32
) (
    input  logic [DATA_SIZE:0]   i_rem,
    input  logic                 i_bit,
    input  logic [DATA_SIZE-1:0] i_divisor,
    output logic [DATA_SIZE:0]   o_rem,
    output logic                 o_q
);
    logic [DATA_SIZE+1:0] shifted;
    logic [DATA_SIZE+1:0] diff;

    // The trial subtraction is one bit wider than the remainder so its MSB
    // is the borrow: no borrow means the divisor fit and the difference is kept.
    always_comb begin
        shifted = {i_rem, i_bit};
        diff    = shifted - {2'b00, i_divisor};
        o_q     = ~diff[DATA_SIZE+1];
        o_rem   = o_q ? diff[DATA_SIZE:0] : shifted[DATA_SIZE:0];
    end
endmodule

// File: rtl/mdu.sv
// mdu: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//   i_clk     rising-edge clock
//   i_reset   synchronous active-low reset
//   bus       mdu_if slave: request, operands, MTHI/MTLO, busy/done, HI/LO
// IDLE -> PREP (1) -> CALC (DATA_SIZE) -> FIX (1) -> IDLE.
module mdu
    import mdu_pkg::*;
#(
    parameter int DATA_SIZE = MDU_DATA_SIZE
) (
    input  logic  i_clk,
    input  logic  i_reset,
    mdu_if.slave  bus
);
    localparam int W  = DATA_SIZE;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    mdu_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [2*W:0]   prod_q, prod_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           div0_q, div0_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic           a_neg, b_neg;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     mul_sum;
    logic [W:0]     step_rem;
    logic           step_q;
    logic [2*W-1:0] mul_res;
    logic [W-1:0]   quo_res, rem_res;

    // prod_q is shared: for multiply {acc, multiplier}, for divide
    // {remainder, dividend/quotient}; the quotient shifts in as the dividend shifts out.
    mdu_div_step #(.DATA_SIZE(W)) u_div_step (
        .i_rem     (prod_q[2*W:W]),
        .i_bit     (prod_q[W-1]),
        .i_divisor (opnd_q),
        .o_rem     (step_rem),
        .o_q       (step_q)
    );

    assign a_neg   = op_is_signed(op_q) & a_q[W-1];
    assign b_neg   = op_is_signed(op_q) & b_q[W-1];
    assign abs_a   = a_neg ? -a_q : a_q;
    assign abs_b   = b_neg ? -b_q : b_q;
    assign mul_sum = prod_q[2*W:W] + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_res = neg_res_q ? -prod_q[2*W-1:0] : prod_q[2*W-1:0];
    assign quo_res = neg_res_q ? -prod_q[W-1:0] : prod_q[W-1:0];
    assign rem_res = neg_rem_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];

    // Next-state and datapath control; everything holds unless a state acts on it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                // A start request takes priority over a simultaneous move.
                if (bus.i_start) begin
                    state_d = MDU_PREP;
                    op_d    = bus.i_op;
                    a_d     = bus.i_data_a;
                    b_d     = bus.i_data_b;
                end else begin
                    if (bus.i_mthi) hi_d = bus.i_data_a;
                    if (bus.i_mtlo) lo_d = bus.i_data_a;
                end
            end
            MDU_PREP: begin
                opnd_d    = op_is_div(op_q) ? abs_b : abs_a;
                prod_d    = {{(W+1){1'b0}}, (op_is_div(op_q) ? abs_a : abs_b)};
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                div0_d    = op_is_div(op_q) & (b_q == '0);
                cnt_d     = '0;
                state_d   = MDU_CALC;
            end
            MDU_CALC: begin
                if (op_is_div(op_q)) begin
                    prod_d = {step_rem, prod_q[W-2:0], step_q};
                end else begin
                    prod_d = {1'b0, mul_sum, prod_q[W-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                // Divide by zero bypasses sign correction entirely.
                if (!op_is_div(op_q)) begin
                    hi_d = mul_res[2*W-1:W];
                    lo_d = mul_res[W-1:0];
                end else if (div0_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end
                done_d  = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_busy = (state_q != MDU_IDLE);
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
endmodule
